uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers (motor telemetry, debug, status). It accepts one byte per valid/ready handshake and drives the transmitter's tx_data, tx_start and baud_division. It sequences one frame at a time using the transmitter's uart_busy status. It sits between the producer blocks and the uart module in the FPGA top level.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 130 +++++++++++++
 tb/tb_uart_tx_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    localparam int         BUSY_TIMEOUT_DEFAULT = 64;
    localparam logic [7:0] BAUD_DIV_MIN         = 8'd1;

    // A division ratio of zero would stall the uart, so it is raised to the minimum.
    function automatic logic [7:0] clamp_baud_div(input logic [7:0] cfg);
        return (cfg == 8'd0) ? BAUD_DIV_MIN : cfg;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any_req
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        idx       = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin sharing of one uart transmitter among byte producers
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT,
    localparam int IW           = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           baud_div_cfg,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic [7:0]           baud_division,
    input  logic                 uart_busy,
    output logic [IW-1:0]        grant_id,
    output logic                 sched_busy,
    output logic                 timeout_err
);

    localparam int             CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic [IW-1:0]       last_grant;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                accept;
    logic                expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    // Next-state and handshake decode; req_ready is held off while reset is asserted.
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        req_ready = '0;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any && !uart_busy && !reset) begin
                    accept    = 1'b1;
                    req_ready = arb_grant;
                    state_nxt = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = GAP;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        sched_busy = (state != IDLE);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycles spent in START waiting for the uart to report busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == START && !uart_busy && !expire) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Frame parameters are captured only on the accept edge and held until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_data       <= '0;
            baud_division <= '0;
            grant_id      <= '0;
            last_grant    <= IW'(NUM_REQ - 1);
        end else if (accept) begin
            tx_data       <= req_data[{arb_idx, 3'b000} +: 8];
            baud_division <= clamp_baud_div(baud_div_cfg);
            grant_id      <= arb_idx;
            last_grant    <= arb_idx;
        end
    end

    // Timeout pulse lands in the GAP cycle that follows an abandoned START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int TO = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    baud_div_cfg = '0;
    logic [N-1:0]  req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic [7:0]    baud_division;
    logic          uart_busy;
    logic [1:0]    grant_id;
    logic          sched_busy;
    logic          timeout_err;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  viol = 0;
    int  rdy_cycles = 0;

    bit  model_en = 1'b1;
    int  model_delay = 2;
    int  model_len = 100;
    bit  ext_busy = 1'b0;
    logic model_busy;
    int  st_cnt;
    int  bz_cnt;

    assign uart_busy = model_busy | ext_busy;

    uart_tx_sched #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .baud_div_cfg  (baud_div_cfg),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .baud_division (baud_division),
        .uart_busy     (uart_busy),
        .grant_id      (grant_id),
        .sched_busy    (sched_busy),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    // Uart model: busy rises model_delay cycles after tx_start, stays up model_len cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_busy <= 1'b0;
            st_cnt     <= 0;
            bz_cnt     <= 0;
        end else if (model_busy) begin
            if (bz_cnt == model_len - 1) model_busy <= 1'b0;
            bz_cnt <= bz_cnt + 1;
        end else if (tx_start && model_en) begin
            if (st_cnt == model_delay - 1) begin
                model_busy <= 1'b1;
                bz_cnt     <= 0;
                st_cnt     <= 0;
            end else begin
                st_cnt <= st_cnt + 1;
            end
        end else begin
            st_cnt <= 0;
        end
    end

    // Invariants: at most one ready bit, and only while idle.
    always @(negedge clock) begin
        if (!reset) begin
            if ($countones(req_ready) > 1 || (req_ready != '0 && sched_busy)) viol++;
            if (req_ready != '0) rdy_cycles++;
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [7:0]  cfg;
        int          delay;
        int          len;
        int          g;
        logic [7:0]  exp_data;
        logic [7:0]  exp_baud;
        bit          exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (sched_busy && k < budget) begin
            k++;
            tick();
        end
        chk("idle_reached", sched_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, tx_start, 1'b0);
        chk({tag, "_req_ready"}, req_ready, 4'b0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_baud"}, baud_division, 8'h00);
        chk({tag, "_grant_id"}, grant_id, 2'd0);
        chk({tag, "_sched_busy"}, sched_busy, 1'b0);
        chk({tag, "_timeout"}, timeout_err, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        bit to_early;
        int n;
        int m;
        model_en     = (v.delay != 0);
        model_delay  = v.delay;
        model_len    = v.len;
        baud_div_cfg = v.cfg;
        req_data     = v.data;
        req_valid    = v.valid;
        #1;
        wait_ready(300, ok);
        chk("ready_seen", ok, 1'b1);
        chk("req_ready", req_ready, 32'(1) << v.g);
        tick();
        req_valid = '0;
        chk("tx_start_latency", tx_start, 1'b1);
        chk("tx_data", tx_data, v.exp_data);
        chk("baud_division", baud_division, v.exp_baud);
        chk("grant_id", grant_id, v.g);
        n = 0;
        to_early = 1'b0;
        while (tx_start && n < 300) begin
            if (timeout_err) to_early = 1'b1;
            n++;
            tick();
        end
        chk("start_cycles", n, v.exp_to ? TO : v.delay + 1);
        chk("timeout_early", to_early, 1'b0);
        chk("timeout_pulse", timeout_err, v.exp_to);
        m = n;
        while (sched_busy && m < 600) begin
            m++;
            tick();
        end
        chk("idle_offset", m, v.exp_to ? TO + 1 : v.delay + v.len + 2);
        chk("hold_tx_data", tx_data, v.exp_data);
    endtask

    initial begin
        bit ok;
        int cnt;
        int r0;
        logic [7:0] fair_data [5];
        int fair_g [5];

        vecs[0] = '{4'b0001, 32'h0000_00A6, 8'd5,   2, 100, 0, 8'hA6, 8'd5,   1'b0};
        vecs[1] = '{4'b0110, 32'h0077_5C00, 8'd0,   2, 20,  1, 8'h5C, 8'd1,   1'b0};
        vecs[2] = '{4'b0011, 32'h0000_993E, 8'd200, 1, 20,  0, 8'h3E, 8'd200, 1'b0};
        vecs[3] = '{4'b1000, 32'hF000_0000, 8'd9,   0, 20,  3, 8'hF0, 8'd9,   1'b1};
        vecs[4] = '{4'b1001, 32'h3400_0012, 8'd7,   3, 15,  0, 8'h12, 8'd7,   1'b0};
        vecs[5] = '{4'b1100, 32'hD4C3_0000, 8'd255, 2, 20,  2, 8'hC3, 8'd255, 1'b0};
        fair_g    = '{0, 1, 2, 3, 0};
        fair_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // All four requesters valid after a fresh reset: strict rotation from 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_en = 1'b1; model_delay = 2; model_len = 10;
        baud_div_cfg = 8'd5;
        req_data = 32'h4433_2211;
        req_valid = 4'b1111;
        r0 = rdy_cycles;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(200, ok);
            chk("fair_ready", req_ready, 32'(1) << fair_g[k]);
            tick();
            chk("fair_data", tx_data, fair_data[k]);
            wait_idle(200);
        end
        req_valid = '0;
        wait_idle(200);
        chk("fair_ready_pulses", rdy_cycles - r0, 5);

        // Reset while START drives tx_start: tx_start must fall immediately.
        model_en = 1'b0;
        req_valid = 4'b0001;
        #1;
        wait_ready(50, ok);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("pre_reset_start", tx_start, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_start");
        tick();
        reset = 1'b0;
        tick();

        // Reset during WAIT_DONE after granting requester 2; pointer must return to 3.
        model_en = 1'b1; model_delay = 2; model_len = 50;
        req_data = 32'h0000_5500;
        req_valid = 4'b0100;
        #1;
        wait_ready(50, ok);
        chk("rst_wait_grant2", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1001;
        for (int k = 0; k < 5; k++) tick();
        chk("in_wait_done", {sched_busy, tx_start}, 2'b10);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        tick();
        reset = 1'b0;
        #1;
        wait_ready(50, ok);
        chk("post_reset_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_idle(200);

        // Baud change mid-frame applies only at the next accept.
        model_len = 30;
        baud_div_cfg = 8'd5;
        req_valid = 4'b0001;
        #1;
        wait_ready(50, ok);
        tick();
        req_valid = '0;
        baud_div_cfg = 8'd9;
        chk("baud_frame_a", baud_division, 8'd5);
        for (int k = 0; k < 10; k++) tick();
        chk("baud_mid_frame", baud_division, 8'd5);
        wait_idle(200);
        chk("baud_after_frame", baud_division, 8'd5);
        req_valid = 4'b0001;
        #1;
        wait_ready(50, ok);
        tick();
        req_valid = '0;
        chk("baud_next_accept", baud_division, 8'd9);
        wait_idle(200);

        // External busy blocks grants; release grants in the same cycle.
        ext_busy = 1'b1;
        req_data = 32'h0000_BE00;
        req_valid = 4'b0010;
        cnt = 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (req_ready != '0) cnt++;
            tick();
        end
        chk("busy_block_ready", cnt, 0);
        chk("busy_block_sched", sched_busy, 1'b0);
        ext_busy = 1'b0;
        #1;
        chk("busy_release_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("busy_release_start", tx_start, 1'b1);
        chk("busy_release_grant", grant_id, 2'd1);
        chk("busy_release_data", tx_data, 8'hBE);
        wait_idle(200);

        chk("ready_invariant", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
